// File: rtl/task_dispatcher.sv
// Task dispatcher: walks a task program in frame memory, streams instruction frames and starts cores.
// Latency: Run -> first Insn_Valid after 5 cycles; START follows the last frame; 3 cycles between tasks.
// Backpressure: stalls in WAIT until addressed cores (all cores on a fence when TS_FENCE_EN) are Ready.
module task_dispatcher #(
  parameter int CORES_COUNT    = 16,
  parameter int INSN_COUNT     = 16,
  parameter int INSN_SIZE      = 16,
  parameter int REG_SIZE       = 8,
  parameter int TASK_MEM_DEPTH = 64,
  localparam int W  = INSN_COUNT * INSN_SIZE,
  localparam int AW = $clog2(TASK_MEM_DEPTH),
  localparam int RW = CORES_COUNT * REG_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Mem_We,
  input  logic [AW-1:0]          Mem_Addr,
  input  logic [W-1:0]           Mem_Wdata,
  input  logic                   Run,
  input  logic [CORES_COUNT-1:0] Ready,
  output logic [CORES_COUNT-1:0] Start,
  output logic                   Insn_Valid,
  output logic [W-1:0]           Insn_Data,
  output logic [7:0]             Insn_Frame_Idx,
  output logic [CORES_COUNT-1:0] Init_R0_Vect,
  output logic [RW-1:0]          Init_R0,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WAIT, S_STREAM, S_START
  } state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          ptr_q, ptr_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [7:0]             n_q, n_d;
  logic                   last_q, last_d;
  logic [CORES_COUNT-1:0] m_q, m_d;
  logic [CORES_COUNT-1:0] r0v_q, r0v_d;
  logic [RW-1:0]          r0val_q, r0val_d;
  logic                   vld_q, vld_d;
  logic [7:0]             idx_q, idx_d;
  logic [CORES_COUNT-1:0] init_vect_q, init_vect_d;
  logic [RW-1:0]          init_r0_q, init_r0_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
`ifdef TS_FENCE_EN
  logic                   fence_q, fence_d;
`endif

  logic [W-1:0] mem [TASK_MEM_DEPTH];
  logic [W-1:0] rd_dat_q;
  logic         rd_en;
  logic         wr_en;
  logic         rdy_ok;

  // Host writes are only accepted while idle so a running program never changes under us
  assign wr_en = Mem_We && (state_q == S_IDLE);

  // Frame memory: synchronous write, registered read of the current pointer (not reset)
  always_ff @(posedge clk) begin
    if (wr_en) mem[Mem_Addr] <= Mem_Wdata;
    if (rd_en) rd_dat_q <= mem[ptr_q];
  end

  // Ready condition: addressed cores only, or every core when a fence is honoured
  always_comb begin
    rdy_ok = ((Ready & m_q) == m_q);
`ifdef TS_FENCE_EN
    if (fence_q) rdy_ok = &Ready;
`endif
  end

  // Next-state and datapath control for the header/frame walk
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    last_d      = last_q;
    m_d         = m_q;
    r0v_d       = r0v_q;
    r0val_d     = r0val_q;
    init_vect_d = init_vect_q;
    init_r0_d   = init_r0_q;
    done_d      = done_q;
    err_d       = err_q;
`ifdef TS_FENCE_EN
    fence_d     = fence_q;
`endif
    vld_d       = 1'b0;
    idx_d       = 8'd0;
    rd_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Run) begin
          ptr_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        n_d         = rd_dat_q[7:0];
        last_d      = rd_dat_q[9];
        m_d         = rd_dat_q[16 +: CORES_COUNT];
        r0v_d       = rd_dat_q[16+CORES_COUNT +: CORES_COUNT];
        r0val_d     = rd_dat_q[W-1 -: RW];
`ifdef TS_FENCE_EN
        fence_d     = rd_dat_q[8];
`endif
        ptr_d       = ptr_q + 1'b1;
        init_vect_d = '0;
        init_r0_d   = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = 8'd0;
        if (rdy_ok) begin
          if (n_q != 8'd0) begin
            state_d = S_STREAM;
          end else begin
            init_vect_d = r0v_q;
            init_r0_d   = r0val_q;
            state_d     = S_START;
          end
        end
      end
      S_STREAM: begin
        // One read per cycle; the extra final cycle lets the last frame show before START
        if (cnt_q != n_q) begin
          rd_en = 1'b1;
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q + 8'd1;
          vld_d = 1'b1;
          idx_d = cnt_q;
        end else begin
          init_vect_d = r0v_q;
          init_r0_d   = r0val_q;
          state_d     = S_START;
        end
      end
      S_START: begin
        done_d  = last_q;
        state_d = last_q ? S_IDLE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // A host write that arrives mid-program is dropped and flagged
    if (Mem_We && (state_q != S_IDLE)) err_d = 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      last_q      <= 1'b0;
      m_q         <= '0;
      r0v_q       <= '0;
      r0val_q     <= '0;
      vld_q       <= 1'b0;
      idx_q       <= '0;
      init_vect_q <= '0;
      init_r0_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef TS_FENCE_EN
      fence_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      last_q      <= last_d;
      m_q         <= m_d;
      r0v_q       <= r0v_d;
      r0val_q     <= r0val_d;
      vld_q       <= vld_d;
      idx_q       <= idx_d;
      init_vect_q <= init_vect_d;
      init_r0_q   <= init_r0_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef TS_FENCE_EN
      fence_q     <= fence_d;
`endif
    end
  end

  assign Start          = (state_q == S_START) ? m_q : '0;
  assign Busy           = (state_q != S_IDLE);
  assign Insn_Valid     = vld_q;
  assign Insn_Data      = vld_q ? rd_dat_q : '0;
  assign Insn_Frame_Idx = idx_q;
  assign Init_R0_Vect   = init_vect_q;
  assign Init_R0        = init_r0_q;
  assign Done           = done_q;
  assign Err            = err_q;

endmodule

// File: tb/tb_task_dispatcher.sv
// Directed bench for task_dispatcher: program load, ready stalls, fence, chaining, wrap, error and reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-derived cycle positions relative to the Run pulse.
module tb_task_dispatcher;

  localparam int C  = 16;
  localparam int W  = 256;
  localparam int AW = 6;
  localparam int RW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Mem_We = 1'b0;
  logic [AW-1:0] Mem_Addr = '0;
  logic [W-1:0]  Mem_Wdata = '0;
  logic          Run = 1'b0;
  logic [C-1:0]  Ready = 16'hFFFF;
  logic [C-1:0]  Start;
  logic          Insn_Valid;
  logic [W-1:0]  Insn_Data;
  logic [7:0]    Insn_Frame_Idx;
  logic [C-1:0]  Init_R0_Vect;
  logic [RW-1:0] Init_R0;
  logic          Busy;
  logic          Done;
  logic          Err;

  int n_tests = 0;
  int n_fail  = 0;

  task_dispatcher dut (
    .clk(clk), .rst(rst), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Run(Run), .Ready(Ready), .Start(Start), .Insn_Valid(Insn_Valid), .Insn_Data(Insn_Data),
    .Insn_Frame_Idx(Insn_Frame_Idx), .Init_R0_Vect(Init_R0_Vect), .Init_R0(Init_R0),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] frm(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {16{b, 8'hC3}};
  endfunction

  function automatic logic [W-1:0] mk_hdr(input logic [7:0] n, input logic fence, input logic last,
                                          input logic [15:0] m, input logic [15:0] r0v,
                                          input logic [127:0] r0val);
    logic [W-1:0] h;
    h = '0;
    h[7:0]     = n;
    h[8]       = fence;
    h[9]       = last;
    h[31:16]   = m;
    h[47:32]   = r0v;
    h[255:128] = r0val;
    return h;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mem_wr(input int a, input logic [W-1:0] d);
    Mem_We = 1'b1; Mem_Addr = a[AW-1:0]; Mem_Wdata = d;
    @(negedge clk);
    Mem_We = 1'b0;
  endtask

  // Leaves the caller at the first FETCH cycle
  task automatic run_pulse();
    Run = 1'b1;
    @(negedge clk);
    Run = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".start"}, W'(Start), '0);
    chk({tag, ".valid"}, W'(Insn_Valid), '0);
    chk({tag, ".data"}, Insn_Data, '0);
    chk({tag, ".idx"}, W'(Insn_Frame_Idx), '0);
    chk({tag, ".vect"}, W'(Init_R0_Vect), '0);
    chk({tag, ".r0"}, W'(Init_R0), '0);
    chk({tag, ".busy"}, W'(Busy), '0);
    chk({tag, ".done"}, W'(Done), '0);
    chk({tag, ".err"}, W'(Err), '0);
  endtask

  initial begin
    logic [W-1:0] hdr0;

    // Reset state
    cyc(2);
    chk_idle_outputs("rst");
    rst = 1'b1;
    cyc(1);

    // T1: basic task, header written in the same cycle as Run
    mem_wr(1, frm(1));
    mem_wr(2, frm(2));
    Mem_We = 1'b1; Mem_Addr = '0; Mem_Wdata = mk_hdr(8'd2, 1'b0, 1'b1, 16'h0003, 16'h0001, 128'hA5);
    Run = 1'b1;
    @(negedge clk);
    Mem_We = 1'b0; Run = 1'b0;
    chk("t1.busy_fetch", W'(Busy), 1);
    cyc(3);
    chk("t1.novalid_c4", W'(Insn_Valid), 0);
    cyc(1);
    chk("t1.valid0", W'(Insn_Valid), 1);
    chk("t1.data0", Insn_Data, frm(1));
    chk("t1.idx0", W'(Insn_Frame_Idx), 0);
    cyc(1);
    chk("t1.valid1", W'(Insn_Valid), 1);
    chk("t1.data1", Insn_Data, frm(2));
    chk("t1.idx1", W'(Insn_Frame_Idx), 1);
    cyc(1);
    chk("t1.start", W'(Start), 16'h0003);
    chk("t1.vect", W'(Init_R0_Vect), 16'h0001);
    chk("t1.r0", W'(Init_R0), 128'hA5);
    chk("t1.novalid_start", W'(Insn_Valid), 0);
    chk("t1.busy_start", W'(Busy), 1);
    cyc(1);
    chk("t1.done", W'(Done), 1);
    chk("t1.busy_end", W'(Busy), 0);
    chk("t1.start_end", W'(Start), 0);
    chk("t1.vect_held", W'(Init_R0_Vect), 16'h0001);

    // T2: stall in WAIT until core 0 becomes ready
    Ready = 16'hFFFE;
    mem_wr(0, mk_hdr(8'd1, 1'b0, 1'b1, 16'h0001, 16'h0000, 128'h0));
    mem_wr(1, frm(7));
    run_pulse();
    chk("t2.done_cleared", W'(Done), 0);
    cyc(2);
    repeat (4) begin
      chk("t2.wait_novalid", W'(Insn_Valid), 0);
      chk("t2.wait_nostart", W'(Start), 0);
      chk("t2.wait_busy", W'(Busy), 1);
      cyc(1);
    end
    Ready = 16'hFFFF;
    cyc(1);
    chk("t2.issue_novalid", W'(Insn_Valid), 0);
    cyc(1);
    chk("t2.valid", W'(Insn_Valid), 1);
    chk("t2.data", Insn_Data, frm(7));
    cyc(1);
    chk("t2.start", W'(Start), 16'h0001);
    cyc(1);
    chk("t2.done", W'(Done), 1);

    // T3: fence header with core 15 not ready
    Ready = 16'h7FFF;
    mem_wr(0, mk_hdr(8'd0, 1'b1, 1'b1, 16'h0001, 16'h0000, 128'h0));
    run_pulse();
    cyc(3);
`ifdef TS_FENCE_EN
    chk("t3.fence_stall", W'(Start), 0);
    chk("t3.fence_busy", W'(Busy), 1);
    cyc(2);
    chk("t3.fence_stall2", W'(Start), 0);
    Ready = 16'hFFFF;
    cyc(1);
    chk("t3.fence_start", W'(Start), 16'h0001);
`else
    chk("t3.nofence_start", W'(Start), 16'h0001);
`endif
    cyc(1);
    chk("t3.done", W'(Done), 1);
    Ready = 16'hFFFF;

    // T4: two chained tasks, second START 4 cycles after the first
    mem_wr(0, mk_hdr(8'd1, 1'b0, 1'b0, 16'h0010, 16'h0000, 128'h0));
    mem_wr(1, frm(9));
    mem_wr(2, mk_hdr(8'd0, 1'b0, 1'b1, 16'h0020, 16'h0002, 128'h7700));
    run_pulse();
    cyc(4);
    chk("t4.valid", W'(Insn_Valid), 1);
    chk("t4.data", Insn_Data, frm(9));
    cyc(1);
    chk("t4.start1", W'(Start), 16'h0010);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t4.gap_nostart", W'(Start), 0);
      chk("t4.gap_nodone", W'(Done), 0);
    end
    cyc(1);
    chk("t4.start2", W'(Start), 16'h0020);
    chk("t4.vect2", W'(Init_R0_Vect), 16'h0002);
    chk("t4.r0_2", W'(Init_R0), 128'h7700);
    cyc(1);
    chk("t4.done", W'(Done), 1);

    // T5: header at 63, its single frame wraps to address 0
    hdr0 = mk_hdr(8'd62, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0);
    mem_wr(0, hdr0);
    for (int a = 1; a <= 62; a++) mem_wr(a, frm(a));
    mem_wr(63, mk_hdr(8'd1, 1'b0, 1'b1, 16'h0004, 16'h0000, 128'h0));
    run_pulse();
    cyc(4);
    for (int a = 1; a <= 62; a++) begin
      chk("t5.valid", W'(Insn_Valid), 1);
      chk("t5.data", Insn_Data, frm(a));
      cyc(1);
    end
    chk("t5.noop_start", W'(Start), 0);
    chk("t5.noop_busy", W'(Busy), 1);
    cyc(5);
    chk("t5.wrap_valid", W'(Insn_Valid), 1);
    chk("t5.wrap_data", Insn_Data, hdr0);
    chk("t5.wrap_idx", W'(Insn_Frame_Idx), 0);
    cyc(1);
    chk("t5.start", W'(Start), 16'h0004);
    cyc(1);
    chk("t5.done", W'(Done), 1);
    chk("t5.noerr", W'(Err), 0);

    // T6: write during STREAM is dropped and flagged, then reset mid-STREAM and re-run
    mem_wr(0, mk_hdr(8'd4, 1'b0, 1'b1, 16'h0001, 16'h0001, 128'h3C));
    for (int a = 1; a <= 4; a++) mem_wr(a, frm(a + 16));
    run_pulse();
    cyc(4);
    chk("t6.data0", Insn_Data, frm(17));
    Mem_We = 1'b1; Mem_Addr = 6'd4; Mem_Wdata = {W{1'b1}};
    cyc(1);
    Mem_We = 1'b0;
    chk("t6.err", W'(Err), 1);
    chk("t6.data1", Insn_Data, frm(18));
    cyc(2);
    chk("t6.mem_kept", Insn_Data, frm(20));
    cyc(2);
    chk("t6.err_sticky", W'(Err), 1);
    chk("t6.done", W'(Done), 1);
    run_pulse();
    chk("t6.err_cleared", W'(Err), 0);
    cyc(4);
    chk("t6.pre_rst_valid", W'(Insn_Valid), 1);
    rst = 1'b0;
    #1;
    chk_idle_outputs("t6.rst");
    @(negedge clk);
    rst = 1'b1;
    cyc(1);
    chk("t6.idle_after_rst", W'(Busy), 0);
    run_pulse();
    cyc(4);
    for (int a = 1; a <= 4; a++) begin
      chk("t6.rerun_data", Insn_Data, frm(a + 16));
      chk("t6.rerun_idx", W'(Insn_Frame_Idx), W'(a - 1));
      cyc(1);
    end
    chk("t6.rerun_start", W'(Start), 16'h0001);
    chk("t6.rerun_r0", W'(Init_R0), 128'h3C);
    cyc(1);
    chk("t6.rerun_done", W'(Done), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
